// File: rtl/if_stage_btb_if.sv
// if_stage_btb_if: fetch-stage bus carrying stalls, redirects, BTB training and IF/ID outputs
//   master: pipeline control side (drives stalls, redirects, BTB updates; observes fetch/IF-ID)
//   slave : fetch stage side (consumes control, drives if_addr, if_bios_en and id_*)
interface if_stage_btb_if;
   logic        id_stall;
   logic        ex_stall;
   logic        mem_flush;
   logic        mem_redirect_taken;
   logic [31:0] mem_alu;
   logic        id_target_taken;
   logic [31:0] id_target;
   logic        ex_update_en;
   logic [31:0] ex_update_pc;
   logic [31:0] ex_update_target;
   logic        ex_update_taken;
   logic [31:0] if_addr;
   logic        if_bios_en;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        id_pred_taken;
   logic [31:0] id_pred_target;
   modport master (
      output id_stall, ex_stall, mem_flush, mem_redirect_taken, mem_alu,
             id_target_taken, id_target, ex_update_en, ex_update_pc,
             ex_update_target, ex_update_taken,
      input  if_addr, if_bios_en, id_pc, id_valid, id_pred_taken, id_pred_target
   );
   modport slave (
      input  id_stall, ex_stall, mem_flush, mem_redirect_taken, mem_alu,
             id_target_taken, id_target, ex_update_en, ex_update_pc,
             ex_update_target, ex_update_taken,
      output if_addr, if_bios_en, id_pc, id_valid, id_pred_taken, id_pred_target
   );
endinterface

// File: rtl/if_stage_btb.sv
// if_stage_btb: fetch stage with direct-mapped BTB next-PC prediction and IF/ID register
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of if_stage_btb_if (stalls, redirects, BTB update in; fetch PC, IF/ID out)
module if_stage_btb #(
   parameter logic [31:0] RESET_PC    = 32'h4000_0000,
   parameter int          BTB_ENTRIES = 16,
   parameter int          BIOS_BIT    = 30
) (
   input logic          clk,
   input logic          rst,
   if_stage_btb_if.slave bus
);
   localparam int IDX = $clog2(BTB_ENTRIES);
   localparam int TW  = 30 - IDX;
   logic [31:0]            pc, next_pc;
   logic [BTB_ENTRIES-1:0] valid;
   logic [TW-1:0]          tag_mem [BTB_ENTRIES];
   logic [31:0]            target_mem [BTB_ENTRIES];
   logic [IDX-1:0]         idx, upd_idx;
   logic [TW-1:0]          tag, upd_tag;
   logic                   hit, stall;
   logic [31:0]            id_pc, id_pred_target;
   logic                   id_valid, id_pred_taken;
   assign stall   = bus.id_stall | bus.ex_stall;
   assign idx     = pc[IDX+1:2];
   assign tag     = pc[31:IDX+2];
   assign hit     = valid[idx] && tag_mem[idx] == tag;
   assign upd_idx = bus.ex_update_pc[IDX+1:2];
   assign upd_tag = bus.ex_update_pc[31:IDX+2];
   // MEM redirect outranks stall: the stalled instructions are on the wrong path anyway
   always_comb next_pc = rst ? RESET_PC :
                         bus.mem_redirect_taken ? bus.mem_alu :
                         stall ? pc :
                         bus.id_target_taken ? bus.id_target :
                         hit ? target_mem[idx] : pc + 32'd4;
   always_ff @(posedge clk) pc <= next_pc;
   // An ID redirect turns the instruction currently in IF into a bubble
   always_ff @(posedge clk)
      if (rst || bus.mem_flush || bus.mem_redirect_taken) begin
         id_pc          <= '0;
         id_valid       <= 1'b0;
         id_pred_taken  <= 1'b0;
         id_pred_target <= '0;
      end else if (!stall) begin
         id_pc          <= pc;
         id_valid       <= !bus.id_target_taken;
         id_pred_taken  <= !bus.id_target_taken && hit;
         id_pred_target <= target_mem[idx];
      end
   // Not-taken training only drops the entry if it belongs to this PC
   always_ff @(posedge clk)
      if (rst) valid <= '0;
      else if (bus.ex_update_en)
         valid[upd_idx] <= bus.ex_update_taken || (valid[upd_idx] && tag_mem[upd_idx] != upd_tag);
   always_ff @(posedge clk)
      if (bus.ex_update_en && bus.ex_update_taken) begin
         tag_mem[upd_idx]    <= upd_tag;
         target_mem[upd_idx] <= bus.ex_update_target;
      end
   assign bus.if_addr        = pc;
   assign bus.if_bios_en     = pc[BIOS_BIT];
   assign bus.id_pc          = id_pc;
   assign bus.id_valid       = id_valid;
   assign bus.id_pred_taken  = id_pred_taken;
   assign bus.id_pred_target = id_pred_target;
endmodule

// File: tb/tb_if_stage_btb.sv
// tb_if_stage_btb: directed plan plus randomized traffic checked against a behavioural fetch/BTB model
module tb_if_stage_btb;
   localparam logic [31:0] RPC = 32'h4000_0000;
   localparam int          NE  = 16;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   if_stage_btb_if bus();
   if_stage_btb dut (.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0, n_pass = 0;
   logic [31:0] m_pc = '0, m_ipc = '0, m_itg = '0;
   logic        m_idv = 1'b0, m_ipt = 1'b0, ck_pc = 1'b1, ck_tg = 1'b1;
   logic        m_v   [NE];
   logic [31:0] m_tag [NE];
   logic [31:0] m_tgt [NE];
   initial for (int i = 0; i < NE; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
   end
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic idle();
      bus.id_stall = 0; bus.ex_stall = 0; bus.mem_flush = 0;
      bus.mem_redirect_taken = 0; bus.mem_alu = '0;
      bus.id_target_taken = 0; bus.id_target = '0;
      bus.ex_update_en = 0; bus.ex_update_pc = '0;
      bus.ex_update_target = '0; bus.ex_update_taken = 0;
   endtask
   task automatic model();
      int unsigned i, j;
      logic st, h;
      logic [31:0] npc;
      st = bus.id_stall | bus.ex_stall;
      i  = (m_pc >> 2) % NE;
      h  = m_v[i] && m_tag[i] == (m_pc >> 6);
      if (rst) begin
         npc = RPC;
         m_idv = 0; m_ipt = 0; m_ipc = '0; m_itg = '0; ck_pc = 1; ck_tg = 1;
         for (int k = 0; k < NE; k++) m_v[k] = 1'b0;
      end else begin
         npc = bus.mem_redirect_taken ? bus.mem_alu : st ? m_pc :
               bus.id_target_taken ? bus.id_target : h ? m_tgt[i] : m_pc + 32'd4;
         if (bus.mem_flush || bus.mem_redirect_taken) begin
            m_idv = 0; m_ipt = 0; m_ipc = '0; m_itg = '0; ck_pc = 1; ck_tg = 1;
         end else if (!st) begin
            if (bus.id_target_taken) begin
               m_idv = 0; m_ipt = 0; ck_pc = 0; ck_tg = 0;
            end else begin
               m_idv = 1; m_ipt = h; m_ipc = m_pc; m_itg = m_tgt[i]; ck_pc = 1; ck_tg = h;
            end
         end
         if (bus.ex_update_en) begin
            j = (bus.ex_update_pc >> 2) % NE;
            if (bus.ex_update_taken) begin
               m_v[j] = 1; m_tag[j] = bus.ex_update_pc >> 6; m_tgt[j] = bus.ex_update_target;
            end else if (m_tag[j] == (bus.ex_update_pc >> 6)) m_v[j] = 0;
         end
      end
      m_pc = npc;
   endtask
   task automatic step();
      @(posedge clk);
      model();
      #1;
      check("if_addr", bus.if_addr, m_pc);
      check("if_bios_en", 32'(bus.if_bios_en), 32'(m_pc[30]));
      check("id_valid", 32'(bus.id_valid), 32'(m_idv));
      check("id_pred_taken", 32'(bus.id_pred_taken), 32'(m_ipt));
      if (ck_pc) check("id_pc", bus.id_pc, m_ipc);
      if (ck_tg) check("id_pred_target", bus.id_pred_target, m_itg);
   endtask
   task automatic redirect(logic [31:0] a);
      bus.mem_redirect_taken = 1; bus.mem_alu = a;
      step();
      bus.mem_redirect_taken = 0;
   endtask
   task automatic train(logic [31:0] p, logic [31:0] t, logic tk);
      bus.ex_update_en = 1; bus.ex_update_pc = p; bus.ex_update_target = t; bus.ex_update_taken = tk;
   endtask
   initial begin
      idle();
      rst = 1;
      step();
      check("rst_addr", bus.if_addr, RPC);
      check("rst_bios", 32'(bus.if_bios_en), 1);
      check("rst_valid", 32'(bus.id_valid), 0);
      check("rst_pt", 32'(bus.id_pred_taken), 0);
      check("rst_pc", bus.id_pc, 0);
      check("rst_ptg", bus.id_pred_target, 0);
      rst = 0;
      step();
      check("seq1", bus.if_addr, 32'h4000_0004);
      check("seq1_v", 32'(bus.id_valid), 1);
      step();
      check("seq2", bus.if_addr, 32'h4000_0008);
      check("seq2_pt", 32'(bus.id_pred_taken), 0);
      redirect(RPC);
      train(32'h4000_0008, 32'h4000_0100, 1);
      step();
      bus.ex_update_en = 0;
      step();
      step();
      check("btb_hit", bus.if_addr, 32'h4000_0100);
      check("pred_taken", 32'(bus.id_pred_taken), 1);
      check("pred_tgt", bus.id_pred_target, 32'h4000_0100);
      redirect(32'h4000_0048);
      step();
      check("alias", bus.if_addr, 32'h4000_004C);
      bus.id_stall = 1;
      redirect(32'h1000_0000);
      bus.id_stall = 0;
      check("stall_redir", bus.if_addr, 32'h1000_0000);
      check("stall_redir_v", 32'(bus.id_valid), 0);
      check("stall_redir_bios", 32'(bus.if_bios_en), 0);
      step();
      bus.ex_stall = 1; bus.id_target_taken = 1; bus.id_target = 32'h4000_0200;
      for (int k = 0; k < 3; k++) begin
         step();
         check("frz_addr", bus.if_addr, 32'h1000_0004);
         check("frz_pc", bus.id_pc, 32'h1000_0000);
         check("frz_v", 32'(bus.id_valid), 1);
      end
      bus.ex_stall = 0;
      step();
      check("idt_addr", bus.if_addr, 32'h4000_0200);
      check("idt_bubble", 32'(bus.id_valid), 0);
      bus.id_target_taken = 0;
      step();
      check("idt_after", 32'(bus.id_valid), 1);
      train(32'h4000_0048, '0, 0);
      redirect(RPC);
      bus.ex_update_en = 0;
      step();
      step();
      step();
      check("inv_nomatch", bus.if_addr, 32'h4000_0100);
      train(32'h4000_0008, '0, 0);
      redirect(RPC);
      bus.ex_update_en = 0;
      step();
      step();
      step();
      check("inv_match", bus.if_addr, 32'h4000_000C);
      train(32'h4000_0004, 32'h4000_0300, 1);
      redirect(RPC);
      bus.ex_update_en = 0;
      step();
      step();
      check("trained4", bus.if_addr, 32'h4000_0300);
      rst = 1;
      step();
      rst = 0;
      step();
      check("post_rst4", bus.if_addr, 32'h4000_0004);
      step();
      check("post_rst8", bus.if_addr, 32'h4000_0008);
      redirect(32'hFFFF_FFFC);
      step();
      check("wrap", bus.if_addr, 32'h0000_0000);
      for (int c = 0; c < 500; c++) begin
         rst = $urandom_range(0, 59) == 0;
         bus.id_stall = $urandom_range(0, 5) == 0;
         bus.ex_stall = $urandom_range(0, 6) == 0;
         bus.mem_flush = $urandom_range(0, 11) == 0;
         bus.mem_redirect_taken = $urandom_range(0, 14) == 0;
         bus.mem_alu = RPC | ($urandom_range(0, 127) << 2);
         bus.id_target_taken = $urandom_range(0, 9) == 0;
         bus.id_target = RPC | ($urandom_range(0, 127) << 2);
         bus.ex_update_en = !rst && $urandom_range(0, 2) == 0;
         bus.ex_update_pc = $urandom_range(0, 1) ? m_pc + 32'($urandom_range(0, 3) * 4)
                                                 : RPC | ($urandom_range(0, 127) << 2);
         bus.ex_update_target = RPC | ($urandom_range(0, 127) << 2);
         bus.ex_update_taken = $urandom_range(0, 3) != 0;
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
